// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns execute results into data-memory requests
// and produces a one-cycle writeback pulse with error status.
module mem_access_stage #(
    parameter  int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned XLEN           = 64,
    localparam int unsigned AW             = 32,
    localparam int unsigned DW             = 32,
    localparam int unsigned RW             = 5,
    localparam int unsigned EW             = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [DW-1:0]   store_data,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic [RW-1:0]   dest_reg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [AW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic            dmem_ack,
    input  logic [DW-1:0]   dmem_rdata,
    output logic            wb_valid,
    output logic            wb_en,
    output logic [RW-1:0]   wb_addr,
    output logic [DW-1:0]   wb_data,
    output logic [EW-1:0]   err
);

    localparam int unsigned CNT_W = 8;

    localparam logic [EW-1:0] ERR_NONE     = 2'b00;
    localparam logic [EW-1:0] ERR_MISALIGN = 2'b01;
    localparam logic [EW-1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [EW-1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_req,       w_req_nxt;
    logic             r_we,        w_we_nxt;
    logic [AW-1:0]    r_addr,      w_addr_nxt;
    logic [DW-1:0]    r_wdata,     w_wdata_nxt;
    logic             r_is_load,   w_is_load_nxt;
    logic             r_reg_write, w_reg_write_nxt;
    logic [RW-1:0]    r_dest,      w_dest_nxt;
    logic             r_wb_valid,  w_wb_valid_nxt;
    logic             r_wb_en,     w_wb_en_nxt;
    logic [RW-1:0]    r_wb_addr,   w_wb_addr_nxt;
    logic [DW-1:0]    r_wb_data,   w_wb_data_nxt;
    logic [EW-1:0]    r_err,       w_err_nxt;

    logic             w_accept;
    logic             w_is_mem;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_start_access;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic             w_unused_alu_hi;

    assign w_unused_alu_hi = ^alu_result[XLEN-1:AW];

    assign in_ready       = (r_state == S_IDLE);
    assign w_accept       = in_valid && (r_state == S_IDLE);
    assign w_is_mem       = mem_read || mem_write;
    assign w_illegal      = mem_read && mem_write;
    assign w_misaligned   = w_is_mem && (alu_result[1:0] != 2'b00);
    assign w_start_access = w_accept && w_is_mem && !w_illegal && !w_misaligned;
    assign w_cnt_inc      = r_cnt + CNT_W'(1);
    // An ack in the final wait cycle wins over the timeout.
    assign w_timeout      = (r_state == S_ACCESS) && !dmem_ack
                            && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_access) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dmem_ack || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered request, writeback and bookkeeping fields.
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_req_nxt       = r_req;
        w_we_nxt        = r_we;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_is_load_nxt   = r_is_load;
        w_reg_write_nxt = r_reg_write;
        w_dest_nxt      = r_dest;
        w_wb_valid_nxt  = 1'b0;
        w_wb_en_nxt     = 1'b0;
        w_wb_addr_nxt   = r_wb_addr;
        w_wb_data_nxt   = r_wb_data;
        w_err_nxt       = ERR_NONE;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dest_nxt      = dest_reg;
                    w_reg_write_nxt = reg_write;
                    w_is_load_nxt   = mem_read;
                    w_wb_addr_nxt   = dest_reg;
                    if (w_illegal) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_data_nxt  = alu_result[AW-1:0];
                        w_err_nxt      = ERR_ILLEGAL;
                    end else if (w_misaligned) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_data_nxt  = alu_result[AW-1:0];
                        w_err_nxt      = ERR_MISALIGN;
                    end else if (w_is_mem) begin
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = mem_write;
                        w_addr_nxt  = alu_result[AW-1:0];
                        w_wdata_nxt = store_data;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_en_nxt    = reg_write && (dest_reg != '0);
                        w_wb_data_nxt  = alu_result[AW-1:0];
                    end
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    w_req_nxt      = 1'b0;
                    w_we_nxt       = 1'b0;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_en_nxt    = r_is_load && r_reg_write && (r_dest != '0);
                    if (r_is_load) begin
                        w_wb_data_nxt = dmem_rdata;
                    end
                end else if (w_timeout) begin
                    w_req_nxt      = 1'b0;
                    w_we_nxt       = 1'b0;
                    w_wb_valid_nxt = 1'b1;
                    w_err_nxt      = ERR_TIMEOUT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_req_nxt = 1'b0;
                w_we_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_load   <= 1'b0;
            r_reg_write <= 1'b0;
            r_dest      <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_err       <= ERR_NONE;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_req       <= w_req_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_is_load   <= w_is_load_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_dest      <= w_dest_nxt;
            r_wb_valid  <= w_wb_valid_nxt;
            r_wb_en     <= w_wb_en_nxt;
            r_wb_addr   <= w_wb_addr_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_en      = r_wb_en;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign err        = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level schedule of expected outputs per
// cycle, checked every cycle, plus hand-computed literal checks.
module tb_mem_access_stage;

    localparam int unsigned T    = 4;
    localparam int          NCYC = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read, mem_write, reg_write;
    logic [4:0]  dest_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  err;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .store_data (store_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .dest_reg   (dest_reg),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_cnt = 0;
    int last_wb = -1;
    bit run = 1'b0;

    // Expected outputs for the cycle following posedge number n.
    logic        exp_rdy   [NCYC];
    logic        exp_req   [NCYC];
    logic        exp_we    [NCYC];
    logic [31:0] exp_addr  [NCYC];
    logic [31:0] exp_wdata [NCYC];
    logic        exp_wbv   [NCYC];
    logic        exp_en    [NCYC];
    logic [4:0]  exp_waddr [NCYC];
    logic        exp_chkd  [NCYC];
    logic [31:0] exp_wdat  [NCYC];
    logic [1:0]  exp_err   [NCYC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic sched_wb(input int idx, input logic en, input logic [4:0] a,
                            input logic chkd, input logic [31:0] d, input logic [1:0] e);
        exp_wbv[idx]   = 1'b1;
        exp_en[idx]    = en;
        exp_waddr[idx] = a;
        exp_chkd[idx]  = chkd;
        exp_wdat[idx]  = d;
        exp_err[idx]   = e;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dmem_req === 1'b1) req_cnt++;
        if (wb_valid === 1'b1) last_wb = cyc;
        if (run && cyc < NCYC) begin
            chk("in_ready", 64'(in_ready), 64'(exp_rdy[cyc]));
            chk("dmem_req", 64'(dmem_req), 64'(exp_req[cyc]));
            if (exp_req[cyc]) begin
                chk("dmem_we", 64'(dmem_we), 64'(exp_we[cyc]));
                chk("dmem_addr", 64'(dmem_addr), 64'(exp_addr[cyc]));
                chk("dmem_wdata", 64'(dmem_wdata), 64'(exp_wdata[cyc]));
            end
            chk("wb_valid", 64'(wb_valid), 64'(exp_wbv[cyc]));
            if (exp_wbv[cyc]) begin
                chk("wb_en", 64'(wb_en), 64'(exp_en[cyc]));
                chk("wb_addr", 64'(wb_addr), 64'(exp_waddr[cyc]));
                chk("err", 64'(err), 64'(exp_err[cyc]));
                if (exp_chkd[cyc]) chk("wb_data", 64'(wb_data), 64'(exp_wdat[cyc]));
            end else begin
                chk("err_idle", 64'(err), 64'(0));
            end
        end
    end

    // d = cycle of ACCESS in which ack is driven (1..T), 0 = never.
    task automatic issue(input logic rd, input logic wr, input logic rw, input logic [4:0] dst,
                         input logic [63:0] alu, input logic [31:0] sd, input int d,
                         input logic [31:0] rdata, output int a, output int w);
        int  acc;
        int  wbc;
        int  n;
        bit  ok;
        in_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        reg_write  = rw;
        dest_reg   = dst;
        alu_result = alu;
        store_data = sd;
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        @(posedge clk); #1;
        acc = cyc;
        if (rd && wr) begin
            wbc = acc;
            sched_wb(wbc, 1'b0, dst, 1'b0, 32'h0, 2'b11);
        end else if ((rd || wr) && alu[1:0] != 2'b00) begin
            wbc = acc;
            sched_wb(wbc, 1'b0, dst, 1'b0, 32'h0, 2'b01);
        end else if (rd || wr) begin
            ok = (d >= 1 && d <= int'(T));
            n  = ok ? d : int'(T);
            for (int k = 0; k < n; k++) begin
                exp_req[acc+k]   = 1'b1;
                exp_rdy[acc+k]   = 1'b0;
                exp_we[acc+k]    = wr;
                exp_addr[acc+k]  = alu[31:0];
                exp_wdata[acc+k] = sd;
            end
            wbc = acc + n;
            if (ok) sched_wb(wbc, rd && rw && (dst != 5'd0), dst, rd, rdata, 2'b00);
            else    sched_wb(wbc, 1'b0, dst, 1'b0, 32'h0, 2'b10);
        end else begin
            wbc = acc;
            sched_wb(wbc, rw && (dst != 5'd0), dst, 1'b1, alu[31:0], 2'b00);
        end
        while (cyc < wbc) begin
            in_valid   = 1'b1;
            alu_result = {$urandom, $urandom};
            store_data = $urandom;
            mem_read   = 1'($urandom);
            mem_write  = 1'($urandom);
            reg_write  = 1'($urandom);
            dest_reg   = 5'($urandom);
            dmem_ack   = (d >= 1) && (cyc - acc == d - 1);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        dmem_ack = 1'b0;
        a = acc;
        w = wbc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b0;
            alu_result = {$urandom, $urandom};
            mem_read   = 1'($urandom);
            mem_write  = 1'($urandom);
            dmem_ack   = 1'($urandom);
            dmem_rdata = $urandom;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int w;
        int r0;
        int acc;
        for (int i = 0; i < NCYC; i++) begin
            exp_rdy[i] = 1'b1; exp_req[i] = 1'b0; exp_we[i] = 1'b0;
            exp_addr[i] = '0; exp_wdata[i] = '0; exp_wbv[i] = 1'b0;
            exp_en[i] = 1'b0; exp_waddr[i] = '0; exp_chkd[i] = 1'b0;
            exp_wdat[i] = '0; exp_err[i] = '0;
        end
        reset = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; dest_reg = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_dmem_req", 64'(dmem_req), 64'(0));
        chk("rst_dmem_we", 64'(dmem_we), 64'(0));
        chk("rst_dmem_addr", 64'(dmem_addr), 64'(0));
        chk("rst_dmem_wdata", 64'(dmem_wdata), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_wb_en", 64'(wb_en), 64'(0));
        chk("rst_wb_data", 64'(wb_data), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run   = 1'b1;
        idle(2);

        // ADD-style op
        r0 = req_cnt;
        issue(1'b0, 1'b0, 1'b1, 5'd3, 64'h5, 32'h0, 0, 32'h0, a, w);
        chk("add_wb_valid", 64'(wb_valid), 64'(1));
        chk("add_wb_en", 64'(wb_en), 64'(1));
        chk("add_wb_addr", 64'(wb_addr), 64'(3));
        chk("add_wb_data", 64'(wb_data), 64'h5);
        chk("add_err", 64'(err), 64'(0));
        idle(2);
        chk("add_no_req", 64'(req_cnt - r0), 64'(0));

        // load 0x100, ack in third ACCESS cycle
        r0 = req_cnt;
        issue(1'b1, 1'b0, 1'b1, 5'd8, 64'h100, 32'h0, 3, 32'hDEADBEEF, a, w);
        chk("ld_wb_data", 64'(wb_data), 64'hDEADBEEF);
        chk("ld_wb_en", 64'(wb_en), 64'(1));
        chk("ld_req_cycles", 64'(req_cnt - r0), 64'(3));
        idle(1);
        chk("ld_latency", 64'(last_wb - a + 1), 64'(4));

        // misaligned store, then load to r0
        r0 = req_cnt;
        issue(1'b0, 1'b1, 1'b0, 5'd2, 64'h202, 32'h1234, 1, 32'h0, a, w);
        chk("mis_err", 64'(err), 64'(1));
        chk("mis_wb_en", 64'(wb_en), 64'(0));
        idle(1);
        chk("mis_no_req", 64'(req_cnt - r0), 64'(0));
        issue(1'b1, 1'b0, 1'b1, 5'd0, 64'h80, 32'h0, 1, 32'hCAFE0001, a, w);
        chk("ld_r0_wb_en", 64'(wb_en), 64'(0));
        idle(1);

        // timeout with no ack, then ack on the final wait cycle
        r0 = req_cnt;
        issue(1'b1, 1'b0, 1'b1, 5'd9, 64'h40, 32'h0, 0, 32'h0, a, w);
        chk("to_err", 64'(err), 64'(2));
        chk("to_wb_en", 64'(wb_en), 64'(0));
        chk("to_req_cycles", 64'(req_cnt - r0), 64'(4));
        @(posedge clk); #1;
        chk("to_in_ready_after", 64'(in_ready), 64'(1));
        issue(1'b1, 1'b0, 1'b1, 5'd10, 64'h44, 32'h0, 4, 32'h600DF00D, a, w);
        chk("late_ack_err", 64'(err), 64'(0));
        chk("late_ack_data", 64'(wb_data), 64'h600DF00D);
        idle(1);

        // illegal control, aligned store
        issue(1'b1, 1'b1, 1'b1, 5'd4, 64'h10, 32'h0, 1, 32'h0, a, w);
        chk("ill_err", 64'(err), 64'(3));
        issue(1'b0, 1'b1, 1'b1, 5'd5, 64'hFFFF_FFFF_0000_0200, 32'hA5A5_5A5A, 2, 32'h0, a, w);
        chk("st_wb_en", 64'(wb_en), 64'(0));

        // back-to-back mix, accepted during each wb_valid cycle
        issue(1'b0, 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF, 32'h0, 0, 32'h0, a, w);
        issue(1'b1, 1'b0, 1'b1, 5'd7, 64'h1004, 32'h0, 1, 32'h0BAD_CAFE, a, w);
        issue(1'b0, 1'b0, 1'b1, 5'd0, 64'h77, 32'h0, 0, 32'h0, a, w);
        issue(1'b0, 1'b1, 1'b0, 5'd6, 64'h2008, 32'h1357_9BDF, 2, 32'h0, a, w);
        issue(1'b1, 1'b0, 1'b1, 5'd12, 64'h101, 32'h0, 1, 32'h0, a, w);
        issue(1'b0, 1'b0, 1'b0, 5'd13, 64'h1234_5678, 32'h0, 0, 32'h0, a, w);
        idle(3);

        // reset during the second ACCESS cycle
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        dest_reg = 5'd4; alu_result = 64'h300; store_data = 32'h55; dmem_ack = 1'b0;
        @(posedge clk); #1;
        acc = cyc;
        exp_req[acc] = 1'b1; exp_rdy[acc] = 1'b0; exp_we[acc] = 1'b0;
        exp_addr[acc] = 32'h300; exp_wdata[acc] = 32'h55;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_req", 64'(dmem_req), 64'(0));
        chk("rst_mid_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        issue(1'b1, 1'b0, 1'b1, 5'd11, 64'h304, 32'h0, 2, 32'h1122_3344, a, w);
        chk("post_rst_data", 64'(wb_data), 64'h1122_3344);
        idle(3);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
